mem_ack_arbiter: RTL

Round-robin arbiter for the shared acknowledge bus. It sits directly downstream of the memory block's ACK port (ACK_VALID / MODULE_SOURCE_ID / ACK_READY) and of every other bus module's equivalent port. It grants the bus to one requester at a time and broadcasts the winning source ID to all listeners as a registered one-cycle VALID_IN / SOURCE_ID_IN pulse.

---
 rtl/mem_ack_pkg.sv | 13 +
 rtl/mem_rr_pick.sv | 36 +++
 rtl/mem_ack_arbiter.sv | 97 +++++++++
 3 files changed

// File: rtl/mem_ack_pkg.sv
// Shared types and default sizing for the acknowledge-bus arbiter.
package mem_ack_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BCAST = 2'd2
  } ack_state_e;

  localparam int ACK_N_REQ = 4;
  localparam int ACK_ID_W  = 2;

endpackage

// File: rtl/mem_rr_pick.sv
// Round-robin winner selection: rotate requests so rr_ptr sits at bit 0,
// take the lowest set bit, then rotate the offset back into an absolute index.
module mem_rr_pick
  import mem_ack_pkg::*;
#(
  parameter int N_REQ = ACK_N_REQ
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] rr_ptr,
  output logic [$clog2(N_REQ)-1:0] win,
  output logic                     any
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0] rot;
  logic [IDX_W-1:0] src;
  int               off;

  always_comb begin
    rot = '0;
    src = '0;
    off = 0;
    for (int i = 0; i < N_REQ; i++) begin
      src    = IDX_W'((i + int'(rr_ptr)) % N_REQ);
      rot[i] = req[src];
    end
    // Scan downwards so the lowest set bit of the rotated vector wins.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = i;
    end
    any = |req;
    win = IDX_W'((int'(rr_ptr) + off) % N_REQ);
  end

endmodule

// File: rtl/mem_ack_arbiter.sv
// Round-robin arbiter for the shared ACK bus: grant one requester, accept its
// source ID, then broadcast that ID as a registered one-cycle pulse.
module mem_ack_arbiter
  import mem_ack_pkg::*;
#(
  parameter int N_REQ = ACK_N_REQ,
  parameter int ID_W  = ACK_ID_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*ID_W-1:0] req_id,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  ack_valid,
  output logic [ID_W-1:0]       ack_id,
  output logic                  err_proto
);

  localparam int IDX_W = $clog2(N_REQ);

  ack_state_e       state, state_n;
  logic [IDX_W-1:0] grant_idx, grant_idx_n;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_n;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic [ID_W-1:0]  ack_id_q, ack_id_n;
  logic             err_q, err_n;
  logic [ID_W-1:0]  id_arr [N_REQ];

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
  endfunction

  for (genvar g = 0; g < N_REQ; g++) begin : g_id
    assign id_arr[g] = req_id[g*ID_W +: ID_W];
  end

  mem_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .win    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    state_n     = state;
    grant_idx_n = grant_idx;
    rr_ptr_n    = rr_ptr;
    ack_id_n    = ack_id_q;
    err_n       = err_q;
    unique case (state)
      ST_IDLE: begin
        if (pick_any) begin
          grant_idx_n = pick_idx;
          state_n     = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // The pointer advances even on a dropped request so a faulty
        // requester cannot monopolise the bus.
        rr_ptr_n = next_idx(grant_idx);
        if (req_valid[grant_idx]) begin
          ack_id_n = id_arr[grant_idx];
          state_n  = ST_BCAST;
        end else begin
          err_n   = 1'b1;
          state_n = ST_IDLE;
        end
      end
      ST_BCAST: state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      grant_idx <= '0;
      rr_ptr    <= '0;
      ack_id_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_n;
      grant_idx <= grant_idx_n;
      rr_ptr    <= rr_ptr_n;
      ack_id_q  <= ack_id_n;
      err_q     <= err_n;
    end
  end

  // Outputs are pure decodes of registered state.
  assign req_ready = (state == ST_GRANT) ? (N_REQ'(1) << grant_idx) : '0;
  assign ack_valid = (state == ST_BCAST);
  assign ack_id    = ack_id_q;
  assign err_proto = err_q;

endmodule
